dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Two-requester arbiter in front of the 8-bit data memory (sync write, comb read).
//  Port 0 = CPU load/store stage, port 1 = DMA/debug loader. Round-robin grant,
//  optional locked bursts with a length cap, address-window check, and one
//  memory access per granted cycle. Drives the memory's sigMemRead/sigMemWrite.
// PARAMETERS
//  LOWER_DMEM_LIMIT   0    lowest legal address (inclusive)
//  HIGHER_DMEM_LIMIT  255  highest legal address (inclusive)
//  MAX_BURST          4    max consecutive locked accesses while other port waits (>=1)
// PORTS
//  clk           in   1  clock, all state on rising edge
//  reset         in   1  asynchronous, active-high
//  req0/req1     in   1  access request, held until ack
//  lock0/lock1   in   1  keep grant for next access (burst)
//  we0/we1       in   1  1 = write, 0 = read
//  addr0/addr1   in   8  address
//  wdata0/wdata1 in   8  write data
//  gnt0/gnt1     out  1  port owns memory this cycle (registered state decode)
//  ack0/ack1     out  1  access completes this cycle (gnt & req)
//  err0/err1     out  1  with ack: address outside window, access suppressed
//  rdata         out  8  readData passthrough; valid for port n when ackn & !weN
//  sigMemRead    out  1  to memory
//  sigMemWrite   out  1  to memory
//  dataAddress   out  8  to memory
//  writeData     out  8  to memory
//  readData      in   8  from memory
// BEHAVIOUR
//  Reset: state IDLE, gnt0/1=0, ack/err=0, last_served=1 (port 0 wins first tie),
//   burst_cnt=0; memory outputs 0. Reset mid-access: grant drops immediately, no write.
//  States: IDLE, GNT0, GNT1 (one-hot or encoded, registered).
//  IDLE: no req -> IDLE; one req -> GNTn; both -> port != last_served. Latency req->ack 1 cycle.
//  GNTn: each cycle with reqn: ackn=1, one access, last_served<=n, burst_cnt++.
//   Next state: other port o pending AND (!reqn OR !lockn OR burst_cnt==MAX_BURST-1) -> GNTo,
//   burst_cnt<=0 (no idle bubble); else reqn & lockn -> stay; else !reqn or !lockn with
//   no other pending -> stay if reqn, IDLE if !reqn. Unlocked req with no contender stays
//   granted (back-to-back at 1 access/cycle).
//  Memory muxing (comb from state): dataAddress/writeData from granted port,
//   sigMemWrite = gnt & req & we & in_window, sigMemRead = gnt & req & !we & in_window;
//   IDLE or req dropped: all memory outputs 0 (no spurious write).
//  in_window = LOWER_DMEM_LIMIT <= addr <= HIGHER_DMEM_LIMIT (8-bit unsigned compare);
//   outside: ack=1, err=1, no memory strobe, rdata forced 0.
//  Write completes at the clk edge ending the ack cycle; a read of the same address
//   on the next cycle returns the new value.
//  burst_cnt: 8-bit saturating, cleared on grant change and in IDLE.
//  gnt0 & gnt1 never both 1; ack implies gnt.
// STRUCTURE
//  Package dmem_arb_pkg: state encoding constants (IDLE/GNT0/GNT1), PORT_CPU=0, PORT_DMA=1.
//  Flat module; no sub-module: FSM + burst counter + output mux in one file.
// TESTING
//  T1 reset: assert reset mid-GNT1 write -> gnt/ack/sigMemWrite 0 same cycle, state IDLE.
//  T2 single: req0 we0=1 addr=8'h10 wdata=8'hA5 -> ack0 next cycle, then read 8'h10 = A5.
//  T3 contention: req0,req1 same cycle from reset -> GNT0 first, then GNT1, alternating.
//  T4 burst: lock1=1, req1 held, req0 pending, MAX_BURST=4 -> exactly 4 ack1 then gnt0.
//  T5 window: LIMITS 16..31, write addr=8'h40 -> ack0 & err0, sigMemWrite 0, mem unchanged.
//  T6 drop: req1 deasserts while GNT1, we1=1 -> sigMemWrite 0, state IDLE next cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, port ids and
// the address-window test used on the granted port's address.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    // Signed int compare keeps a zero lower limit from folding into a constant.
    function automatic logic in_window(input logic [7:0] addr, input int lo, input int hi);
        int a;
        a = int'({24'd0, addr});
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter between the CPU (port 0) and DMA/debug loader (port 1) in
// front of the 8-bit data memory, with capped locked bursts and an address window.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LOWER_DMEM_LIMIT  = 0,
    parameter int HIGHER_DMEM_LIMIT = 255,
    parameter int MAX_BURST         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       lock0,
    input  logic       lock1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata,
    output logic       sigMemRead,
    output logic       sigMemWrite,
    output logic [7:0] dataAddress,
    output logic [7:0] writeData,
    input  logic [7:0] readData,
    output arb_state_e state_dbg_o
);

    arb_state_e state_q, state_d;
    logic       last_served_q, last_served_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;

    logic       sel1;
    logic       act_req, act_lock, act_we, other_req;
    logic [7:0] act_addr, act_wdata;
    logic       access, win, cap_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
            burst_cnt_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

    always_comb begin
        gnt0      = (state_q == ST_GNT0);
        gnt1      = (state_q == ST_GNT1);
        sel1      = gnt1;
        act_req   = sel1 ? req1   : req0;
        act_lock  = sel1 ? lock1  : lock0;
        act_we    = sel1 ? we1    : we0;
        act_addr  = sel1 ? addr1  : addr0;
        act_wdata = sel1 ? wdata1 : wdata0;
        other_req = sel1 ? req0   : req1;
        access    = (gnt0 | gnt1) & act_req;
        win       = in_window(act_addr, LOWER_DMEM_LIMIT, HIGHER_DMEM_LIMIT);
        cap_hit   = (burst_cnt_q == 8'(MAX_BURST - 1));

        ack0        = gnt0 & req0;
        ack1        = gnt1 & req1;
        err0        = ack0 & ~win;
        err1        = ack1 & ~win;
        sigMemWrite = access & act_we & win;
        sigMemRead  = access & ~act_we & win;
        dataAddress = access ? act_addr : 8'd0;
        writeData   = (access & act_we) ? act_wdata : 8'd0;
        rdata       = sigMemRead ? readData : 8'd0;
        state_dbg_o = state_q;
    end

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        burst_cnt_d   = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = 8'd0;
                if (req0 && req1)
                    state_d = last_served_q ? ST_GNT0 : ST_GNT1;
                else if (req0)
                    state_d = ST_GNT0;
                else if (req1)
                    state_d = ST_GNT1;
            end
            ST_GNT0, ST_GNT1: begin
                if (access) begin
                    last_served_d = sel1;
                    burst_cnt_d   = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
                end
                // Hand over without an idle bubble once the owner releases or hits the cap.
                if (other_req && (!act_req || !act_lock || cap_hit)) begin
                    state_d     = sel1 ? ST_GNT0 : ST_GNT1;
                    burst_cnt_d = 8'd0;
                end else if (!act_req) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a per-cycle vector table plus short
// sequences for reset, contention, capped bursts, request drop and window errors.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0, req1, lock0, lock1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;

    logic       gnt0, gnt1, ack0, ack1, err0, err1, mem_rd, mem_wr;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    arb_state_e state_dbg;

    logic       w_gnt0, w_gnt1, w_ack0, w_ack1, w_err0, w_err1, w_mem_rd, w_mem_wr;
    logic [7:0] w_rdata, w_mem_addr, w_mem_wdata, w_mem_rdata;
    arb_state_e w_state_dbg;

    logic [7:0] mem [256];
    logic [7:0] memw [256];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .err0(err0), .err1(err1), .rdata(rdata),
        .sigMemRead(mem_rd), .sigMemWrite(mem_wr),
        .dataAddress(mem_addr), .writeData(mem_wdata), .readData(mem_rdata),
        .state_dbg_o(state_dbg)
    );

    dmem_port_arbiter #(.LOWER_DMEM_LIMIT(16), .HIGHER_DMEM_LIMIT(31), .MAX_BURST(4)) dut_w (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(w_gnt0), .gnt1(w_gnt1), .ack0(w_ack0), .ack1(w_ack1),
        .err0(w_err0), .err1(w_err1), .rdata(w_rdata),
        .sigMemRead(w_mem_rd), .sigMemWrite(w_mem_wr),
        .dataAddress(w_mem_addr), .writeData(w_mem_wdata), .readData(w_mem_rdata),
        .state_dbg_o(w_state_dbg)
    );

    // Clock / reset and memory models
    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr];
    assign w_mem_rdata = memw[w_mem_addr];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (w_mem_wr) memw[w_mem_addr] <= w_mem_wdata;
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'd0; addr1 = 8'd0; wdata0 = 8'd0; wdata1 = 8'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic       req0, req1, we0, we1;
        logic [7:0] addr0, addr1, wdata0, wdata1;
        logic       e_gnt0, e_gnt1, e_ack0, e_ack1, e_wr, e_rd;
        logic [7:0] e_addr, e_rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'd0;
            memw[i] = 8'd0;
        end
        memw[8'h40] = 8'hEE;
        idle_inputs();

        // Reset state
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #2;
        check("rst_gnt0", {7'd0, gnt0}, 8'd0);
        check("rst_gnt1", {7'd0, gnt1}, 8'd0);
        check("rst_ack", {6'd0, ack1, ack0}, 8'd0);
        check("rst_err", {6'd0, err1, err0}, 8'd0);
        check("rst_strobes", {6'd0, mem_wr, mem_rd}, 8'd0);
        check("rst_addr", mem_addr, 8'd0);
        check("rst_state", 8'(state_dbg), 8'(ST_IDLE));

        // Reset asserted mid GNT1 write
        next_cycle();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 8'h77;
        next_cycle();
        #2;
        check("t1_gnt1", {7'd0, gnt1}, 8'd1);
        check("t1_wr_before", {7'd0, mem_wr}, 8'd1);
        reset = 1'b1;
        #1;
        check("t1_gnt1_rst", {7'd0, gnt1}, 8'd0);
        check("t1_ack1_rst", {7'd0, ack1}, 8'd0);
        check("t1_wr_rst", {7'd0, mem_wr}, 8'd0);
        check("t1_state_rst", 8'(state_dbg), 8'(ST_IDLE));
        next_cycle();
        check("t1_mem_unwritten", mem[8'h30], 8'h00);
        do_reset();

        // Per-cycle vectors: single write/read, back-to-back, handover, drop
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
        vecs[1]  = '{1'b1,1'b0,1'b1,1'b0,8'h10,8'h00,8'hA5,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
        vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,8'h10,8'h00,8'hA5,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'h10,8'h00};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,8'h10,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,8'h10,8'hA5};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,8'h20,8'h00,8'h3C,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'h20,8'h00};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,8'h20,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,8'h10,8'h20,8'h00,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h20,8'h3C};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,8'h10,8'h20,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,8'h10,8'hA5};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,8'h10,8'h00,8'h00,8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00};

        for (int i = 0; i < 13; i++) begin
            req0 = vecs[i].req0; req1 = vecs[i].req1;
            we0 = vecs[i].we0; we1 = vecs[i].we1;
            addr0 = vecs[i].addr0; addr1 = vecs[i].addr1;
            wdata0 = vecs[i].wdata0; wdata1 = vecs[i].wdata1;
            #2;
            check($sformatf("v%0d_gnt", i), {6'd0, gnt1, gnt0}, {6'd0, vecs[i].e_gnt1, vecs[i].e_gnt0});
            check($sformatf("v%0d_ack", i), {6'd0, ack1, ack0}, {6'd0, vecs[i].e_ack1, vecs[i].e_ack0});
            check($sformatf("v%0d_strobe", i), {6'd0, mem_wr, mem_rd}, {6'd0, vecs[i].e_wr, vecs[i].e_rd});
            check($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
            next_cycle();
        end
        check("v_mem10", mem[8'h10], 8'hA5);
        check("v_mem20", mem[8'h20], 8'h3C);

        // Contention from reset: port 0 first, then strict alternation
        do_reset();
        begin
            logic [4:0] exp_g0, exp_g1;
            exp_g0 = 5'b01010;
            exp_g1 = 5'b10100;
            req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
            for (int c = 0; c < 5; c++) begin
                #2;
                check($sformatf("t3_gnt0_c%0d", c), {7'd0, gnt0}, {7'd0, exp_g0[c]});
                check($sformatf("t3_gnt1_c%0d", c), {7'd0, gnt1}, {7'd0, exp_g1[c]});
                check($sformatf("t3_ack0_c%0d", c), {7'd0, ack0}, {7'd0, exp_g0[c]});
                next_cycle();
            end
        end

        // Locked burst on port 1 with port 0 waiting: capped at 4 accesses
        do_reset();
        req1 = 1'b1; lock1 = 1'b1; addr1 = 8'h05;
        next_cycle();
        req0 = 1'b1; addr0 = 8'h06;
        begin
            int  acks;
            bit  seen_gnt0;
            acks = 0;
            seen_gnt0 = 1'b0;
            for (int c = 0; c < 20 && !seen_gnt0; c++) begin
                #2;
                check("t4_exclusive", {7'd0, gnt0 & gnt1}, 8'd0);
                if (ack1) acks++;
                if (gnt0) seen_gnt0 = 1'b1;
                else next_cycle();
            end
            check("t4_gnt0_reached", {7'd0, seen_gnt0}, 8'd1);
            check("t4_burst_len", 8'(acks), 8'd4);
            check("t4_ack0", {7'd0, ack0}, 8'd1);
        end

        // Request dropped while GNT1 with a write pending
        do_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h50; wdata1 = 8'h99;
        next_cycle();
        req1 = 1'b0;
        #2;
        check("t6_gnt1", {7'd0, gnt1}, 8'd1);
        check("t6_ack1", {7'd0, ack1}, 8'd0);
        check("t6_wr", {7'd0, mem_wr}, 8'd0);
        next_cycle();
        #2;
        check("t6_state", 8'(state_dbg), 8'(ST_IDLE));
        check("t6_mem", mem[8'h50], 8'h00);

        // Address window 16..31 on the second instance
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h5A;
        next_cycle();
        #2;
        check("t5_ack0", {7'd0, w_ack0}, 8'd1);
        check("t5_err0", {7'd0, w_err0}, 8'd1);
        check("t5_wr", {7'd0, w_mem_wr}, 8'd0);
        next_cycle();
        we0 = 1'b0;
        #2;
        check("t5_mem40", memw[8'h40], 8'hEE);
        check("t5_rd_err", {7'd0, w_err0}, 8'd1);
        check("t5_rd_strobe", {7'd0, w_mem_rd}, 8'd0);
        check("t5_rdata0", w_rdata, 8'h00);
        next_cycle();
        we0 = 1'b1; addr0 = 8'h1F; wdata0 = 8'h66;
        #2;
        check("t5_hi_err", {7'd0, w_err0}, 8'd0);
        check("t5_hi_wr", {7'd0, w_mem_wr}, 8'd1);
        next_cycle();
        we0 = 1'b0; addr0 = 8'h0F;
        #2;
        check("t5_lo_err", {7'd0, w_err0}, 8'd1);
        next_cycle();
        addr0 = 8'h1F;
        #2;
        check("t5_hi_err_rd", {7'd0, w_err0}, 8'd0);
        check("t5_hi_rdata", w_rdata, 8'h66);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
